// File: rtl/cmd_assembler_if.sv
// Byte-in / command-out handshake bundle for cmd_assembler.
// master = byte source and command consumer, slave = the assembler.
interface cmd_assembler_if;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_rx_rdy;
    logic        clr_cmd_rdy;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        overrun;
    logic        timeout;

    modport master (
        output rx_rdy, rx_data, clr_cmd_rdy,
        input  clr_rx_rdy, cmd, cmd_rdy, overrun, timeout
    );

    modport slave (
        input  rx_rdy, rx_data, clr_cmd_rdy,
        output clr_rx_rdy, cmd, cmd_rdy, overrun, timeout
    );
endinterface

// File: rtl/cmd_assembler.sv
// Assembles two received bytes (high, then low) into a 16-bit command.
// Define CMD_TIMEOUT_EN to abandon a half-received command after TIMEOUT_CYC idle cycles.
//
// state   | meaning
// WAIT_HI | idle, next byte is the high byte of a command
// WAIT_LO | high byte held, next byte completes the command
module cmd_assembler #(
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic             clk,
    input  logic             rst_n,
    cmd_assembler_if.slave   bus
);
    typedef enum logic [0:0] {WAIT_HI, WAIT_LO} state_t;

    state_t      state, state_nxt;
    logic        hi_accept, lo_accept;
    logic [7:0]  hi_byte;
    logic [15:0] cmd_q;
    logic        cmd_rdy_q, overrun_q;

`ifdef CMD_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);

    logic [CNT_W-1:0] cnt;
    logic             timeout_hit;
    logic             timeout_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= WAIT_HI;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        hi_accept = 1'b0;
        lo_accept = 1'b0;
`ifdef CMD_TIMEOUT_EN
        timeout_hit = 1'b0;
`endif
        case (state)
            WAIT_HI: begin
                if (bus.rx_rdy) begin
                    hi_accept = 1'b1;
                    state_nxt = WAIT_LO;
                end
            end
            WAIT_LO: begin
                // A byte arriving on the last allowed cycle still completes the command.
                if (bus.rx_rdy) begin
                    lo_accept = 1'b1;
                    state_nxt = WAIT_HI;
                end
`ifdef CMD_TIMEOUT_EN
                else if (cnt == CNT_LAST) begin
                    timeout_hit = 1'b1;
                    state_nxt   = WAIT_HI;
                end
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_byte   <= 8'h00;
            cmd_q     <= 16'h0000;
            cmd_rdy_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (hi_accept) hi_byte <= bus.rx_data;
            if (lo_accept) cmd_q <= {hi_byte, bus.rx_data};

            if (lo_accept)            cmd_rdy_q <= 1'b1;
            else if (bus.clr_cmd_rdy) cmd_rdy_q <= 1'b0;

            if (lo_accept && cmd_rdy_q && !bus.clr_cmd_rdy) overrun_q <= 1'b1;
            else if (bus.clr_cmd_rdy)                        overrun_q <= 1'b0;
        end
    end

`ifdef CMD_TIMEOUT_EN
    // Saturates rather than wraps; in practice the FSM leaves WAIT_LO first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_hit;
            if (hi_accept)
                cnt <= '0;
            else if (state == WAIT_LO && !bus.rx_rdy && cnt != CNT_MAX)
                cnt <= cnt + CNT_W'(1);
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    // State is WAIT_HI throughout reset, so every byte offered is consumed in either state.
    assign bus.clr_rx_rdy = bus.rx_rdy;
    assign bus.cmd        = cmd_q;
    assign bus.cmd_rdy    = cmd_rdy_q;
    assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_cmd_assembler.sv
// Directed bench for cmd_assembler: scoreboard of expected commands plus a small
// model of cmd_rdy/overrun; covers both builds of the timeout feature.
module tb_cmd_assembler;
    localparam int unsigned TO_CYC = 100;

    logic clk;
    logic rst_n;
    cmd_assembler_if bus();

    cmd_assembler #(.TIMEOUT_CYC(TO_CYC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_clr_pulses = 0;
    int n_to_pulses  = 0;

    logic [15:0] exp_q[$];
    logic [7:0]  m_hi;
    logic        m_hi_valid;
    logic        m_rdy;
    logic        m_ovr;

    always @(posedge clk) if (bus.clr_rx_rdy) n_clr_pulses++;
    always @(negedge clk) if (bus.timeout)    n_to_pulses++;

    initial begin
        #1ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_hi_valid = 1'b0;
        m_rdy = 1'b0;
        m_ovr = 1'b0;
        exp_q.delete();
    endtask

    // Offer one byte for one cycle, optionally with clr_cmd_rdy in the same cycle.
    task automatic send_byte(input logic [7:0] b, input logic with_clr, input string tag);
        logic        is_lo;
        logic [15:0] e;
        @(negedge clk);
        bus.rx_rdy      = 1'b1;
        bus.rx_data     = b;
        bus.clr_cmd_rdy = with_clr;
        is_lo = m_hi_valid;
        if (!is_lo) begin
            m_hi = b;
            m_hi_valid = 1'b1;
            if (with_clr) begin m_rdy = 1'b0; m_ovr = 1'b0; end
        end else begin
            exp_q.push_back({m_hi, b});
            m_hi_valid = 1'b0;
            m_ovr = with_clr ? 1'b0 : (m_ovr | m_rdy);
            m_rdy = 1'b1;
        end
        #1;
        chk({tag, "_clr_rx_rdy_hi"}, 32'(bus.clr_rx_rdy), 32'd1);
        @(posedge clk);
        #1;
        bus.rx_rdy      = 1'b0;
        bus.rx_data     = 8'h00;
        bus.clr_cmd_rdy = 1'b0;
        #1;
        chk({tag, "_clr_rx_rdy_lo"}, 32'(bus.clr_rx_rdy), 32'd0);
        if (is_lo) begin
            e = exp_q.pop_front();
            chk({tag, "_cmd"}, 32'(bus.cmd), 32'(e));
        end
        chk({tag, "_cmd_rdy"}, 32'(bus.cmd_rdy), 32'(m_rdy));
        chk({tag, "_overrun"}, 32'(bus.overrun), 32'(m_ovr));
    endtask

    task automatic clr_pulse();
        @(negedge clk);
        bus.clr_cmd_rdy = 1'b1;
        @(posedge clk);
        #1;
        bus.clr_cmd_rdy = 1'b0;
        m_rdy = 1'b0;
        m_ovr = 1'b0;
        chk("clr_cmd_rdy", 32'(bus.cmd_rdy), 32'd0);
        chk("clr_overrun", 32'(bus.overrun), 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int c0;
        int first_to;
        logic [15:0] held;

        rst_n = 1'b0;
        bus.rx_rdy = 1'b0;
        bus.rx_data = 8'h00;
        bus.clr_cmd_rdy = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd",     32'(bus.cmd), 32'h0);
        chk("rst_cmd_rdy", 32'(bus.cmd_rdy), 32'd0);
        chk("rst_overrun", 32'(bus.overrun), 32'd0);
        chk("rst_timeout", 32'(bus.timeout), 32'd0);
        chk("rst_clr_idle", 32'(bus.clr_rx_rdy), 32'd0);
        bus.rx_rdy = 1'b1;
        #1;
        chk("rst_clr_follow", 32'(bus.clr_rx_rdy), 32'd1);
        bus.rx_rdy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Two bytes 50 cycles apart; high byte must not touch cmd/cmd_rdy.
        c0 = n_clr_pulses;
        send_byte(8'hA5, 1'b0, "a5");
        chk("hi_no_cmd", 32'(bus.cmd), 32'h0);
        idle(49);
        send_byte(8'h3C, 1'b0, "3c");
        #1;
        chk("clr_pulse_count", 32'(n_clr_pulses - c0), 32'd2);

        // Clear coincides with next set: set wins, no overrun.
        send_byte(8'h12, 1'b0, "12");
        send_byte(8'h34, 1'b1, "34");
        clr_pulse();

        // Back-to-back commands without clear raise overrun.
        send_byte(8'h01, 1'b0, "01");
        send_byte(8'h02, 1'b0, "02");
        send_byte(8'h03, 1'b0, "03");
        send_byte(8'h04, 1'b0, "04");
        chk("ovr_cmd", 32'(bus.cmd), 32'h0304);
        clr_pulse();

        // Reset while a high byte is held: partial command discarded.
        send_byte(8'h77, 1'b0, "77");
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_cmd", 32'(bus.cmd), 32'h0);
        chk("mid_rst_rdy", 32'(bus.cmd_rdy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send_byte(8'h11, 1'b0, "11");
        send_byte(8'h22, 1'b0, "22");

`ifdef CMD_TIMEOUT_EN
        // High byte then silence: timeout fires exactly TO_CYC edges later.
        held = bus.cmd;
        c0 = n_to_pulses;
        send_byte(8'hFF, 1'b0, "ff");
        first_to = 0;
        for (int k = 1; k <= 150; k++) begin
            @(posedge clk);
            #1;
            if (bus.timeout && first_to == 0) first_to = k;
        end
        m_hi_valid = 1'b0;
        chk("to_latency", 32'(first_to), 32'(TO_CYC));
        chk("to_count", 32'(n_to_pulses - c0), 32'd1);
        chk("to_cmd_held", 32'(bus.cmd), 32'(held));
        chk("to_rdy_held", 32'(bus.cmd_rdy), 32'(m_rdy));
        send_byte(8'h55, 1'b0, "55");
        send_byte(8'hAA, 1'b0, "aa");

        // Low byte on the last allowed cycle wins over timeout.
        c0 = n_to_pulses;
        send_byte(8'h9E, 1'b0, "9e");
        idle(TO_CYC - 1);
        send_byte(8'h61, 1'b0, "61");
        idle(5);
        chk("edge_no_to", 32'(n_to_pulses - c0), 32'd0);
`else
        // No timeout build: a long gap still completes the command.
        send_byte(8'hC3, 1'b0, "c3");
        idle(2000);
        send_byte(8'h0F, 1'b0, "0f");
        chk("no_to_ever", 32'(n_to_pulses), 32'd0);
        held = bus.cmd;
        chk("no_to_cmd", 32'(held), 32'hC30F);
        first_to = 0;
        chk("no_to_first", 32'(first_to + 32'(bus.timeout)), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
